// File: rtl/comms_master.sv
// rtl/comms_master.sv - SPI master streaming a fixed configuration table to the HDP display controller
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_setup    start request (level-sampled; ignored while a sequence is in flight)
//   i_sout     serial reply from the HDP, sampled on SCK rising
//   o_sen      chip select, active low, one frame per table word
//   o_sck      SPI clock, mode 0 (idles low)
//   o_sdat     serial data to the HDP, MSB first, changes on SCK falling
//   o_rx_data  last complete word received on i_sout
//   o_done     sticky flag, set once the whole table has been sent

module comms_master #(
    parameter int CLK_DIV    = 2,
    parameter int WORD_BITS  = 16,
    parameter int NUM_WORDS  = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_setup,
    input  logic                 i_sout,
    output logic                 o_sen,
    output logic                 o_sck,
    output logic                 o_sdat,
    output logic [WORD_BITS-1:0] o_rx_data,
    output logic                 o_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int PH_W  = $clog2(2 * WORD_BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(2 * WORD_BITS);
    localparam logic [PH_W-1:0]  PH_LAST_HIGH = PH_W'(2 * WORD_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DIV_W-1:0]     div;
    logic [PH_W-1:0]      phase;
    logic [GAP_W-1:0]     gap_cnt;
    logic [IDX_W-1:0]     idx;
    logic [WORD_BITS-1:0] tx;
    logic [WORD_BITS-1:0] rx_shift;

    logic                 div_end;
    logic                 start;
    logic                 frame_end;
    logic                 gap_end;
    logic                 last_word;
    logic                 load;
    logic [IDX_W-1:0]     idx_load;
    logic [WORD_BITS-1:0] word_load;

    function automatic logic [WORD_BITS-1:0] rom(input logic [IDX_W-1:0] i);
        case (32'(i))
            0:       rom = WORD_BITS'(16'hA5C3);
            1:       rom = WORD_BITS'(16'h0203);
            2:       rom = WORD_BITS'(16'h0405);
            3:       rom = WORD_BITS'(16'h8001);
            default: rom = '0;
        endcase
    endfunction

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        div_end    = (div == DIV_LAST);
        start      = i_setup && ((state == IDLE) || (state == DONE));
        frame_end  = (state == FRAME) && div_end && (phase == PH_LAST);
        gap_end    = (state == GAP) && (gap_cnt == GAP_LAST);
        last_word  = (idx == IDX_LAST);
        // A word is loaded either by a fresh request or at the end of a gap
        // that still has table entries behind it.
        load       = start || (gap_end && !last_word);
        idx_load   = start ? '0 : idx + IDX_W'(1);
        word_load  = rom(idx_load);
        state_next = state;
        case (state)
            IDLE, DONE: if (start)     state_next = FRAME;
            FRAME:      if (frame_end) state_next = GAP;
            GAP:        if (gap_end)   state_next = last_word ? DONE : FRAME;
            default:                   state_next = IDLE;
        endcase
    end

    // Frame timing: phase 0 is the lead-in, odd phases are SCK high and even
    // phases SCK low; each phase lasts CLK_DIV cycles.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sen     <= 1'b1;
            o_sck     <= 1'b0;
            o_sdat    <= 1'b0;
            o_rx_data <= '0;
            o_done    <= 1'b0;
            div       <= '0;
            phase     <= '0;
            gap_cnt   <= '0;
            idx       <= '0;
            tx        <= '0;
            rx_shift  <= '0;
        end else if (load) begin
            idx    <= idx_load;
            tx     <= word_load;
            o_sdat <= word_load[WORD_BITS-1];
            o_sen  <= 1'b0;
            o_sck  <= 1'b0;
            o_done <= 1'b0;
            div    <= '0;
            phase  <= '0;
        end else begin
            case (state)
                FRAME: begin
                    if (div_end) begin
                        div <= '0;
                        if (phase == PH_LAST) begin
                            o_sen     <= 1'b1;
                            o_sdat    <= 1'b0;
                            o_rx_data <= rx_shift;
                            gap_cnt   <= '0;
                        end else begin
                            phase <= phase + PH_W'(1);
                            if (!phase[0]) begin
                                o_sck    <= 1'b1;
                                rx_shift <= {rx_shift[WORD_BITS-2:0], i_sout};
                            end else begin
                                o_sck <= 1'b0;
                                // The final falling edge keeps the LSB on the line.
                                if (phase != PH_LAST_HIGH) begin
                                    tx     <= {tx[WORD_BITS-2:0], tx[WORD_BITS-1]};
                                    o_sdat <= tx[WORD_BITS-2];
                                end
                            end
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                GAP: begin
                    // A gap end that does not load a word is the end of the table.
                    if (gap_end) begin
                        o_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comms_master.sv
// tb/tb_comms_master.sv - self-checking bench for comms_master against a cycle-timeline reference model

module tb_comms_master;

    localparam int W         = 16;
    localparam int N         = 4;
    localparam int CD        = 2;
    localparam int GAPC      = 4;
    localparam int FRAME_LEN = (2 * W + 1) * CD;
    localparam int WORD_LEN  = FRAME_LEN + GAPC;
    localparam int SEQ_LEN   = N * WORD_LEN;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         setup = 1'b0;
    logic         sout  = 1'b0;
    logic         sen;
    logic         sck;
    logic         sdat;
    logic         done;
    logic [W-1:0] rx;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] table_w [N];
    logic [W-1:0] exp_rx;
    logic [W-1:0] cap;
    logic         prev_sout;

    always #5 clk = ~clk;

    comms_master #(
        .CLK_DIV    (CD),
        .WORD_BITS  (W),
        .NUM_WORDS  (N),
        .GAP_CYCLES (GAPC)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_setup   (setup),
        .i_sout    (sout),
        .o_sen     (sen),
        .o_sck     (sck),
        .o_sdat    (sdat),
        .o_rx_data (rx),
        .o_done    (done)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp, input int t);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int t);
        check({tag, "_sen"}, W'(sen), W'(1), t);
        check({tag, "_sck"}, W'(sck), W'(0), t);
        check({tag, "_sdat"}, W'(sdat), W'(0), t);
        check({tag, "_done"}, W'(done), W'(0), t);
    endtask

    // mode: 0 = i_sout held low, 1 = random i_sout, 2 = loopback of o_sdat.
    // inj_a/inj_b: cycles after which a stray i_setup pulse is driven.
    // abort_t: cycle at which reset is asserted (-1 = never).
    task automatic run_seq(input int mode, input int inj_a, input int inj_b, input int abort_t);
        int   w;
        int   o;
        int   p;
        int   bi;
        logic e_sen;
        logic e_sck;
        logic e_sdat;
        logic e_done;
        cap       = '0;
        setup     = 1'b1;
        sout      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_sout = sout;
        @(posedge clk);
        #1;
        setup = 1'b0;
        for (int t = 0; t < SEQ_LEN + 6; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (t == abort_t) begin
                rst_n = 1'b0;
                #1;
                check_idle("abort_now", t);
                check("abort_rx", rx, '0, t);
                exp_rx = '0;
                repeat (2) @(posedge clk);
                #1;
                check_idle("abort_hold", t);
                rst_n = 1'b1;
                return;
            end
            w = t / WORD_LEN;
            o = t % WORD_LEN;
            if (t < SEQ_LEN && o < FRAME_LEN) begin
                p      = o / CD;
                e_sen  = 1'b0;
                e_sck  = (p % 2) == 1;
                bi     = (p / 2 > W - 1) ? W - 1 : p / 2;
                e_sdat = table_w[w][W-1-bi];
                if ((p % 2) == 1 && (o % CD) == 0) begin
                    cap = {cap[W-2:0], prev_sout};
                end
            end else begin
                e_sen  = 1'b1;
                e_sck  = 1'b0;
                e_sdat = 1'b0;
                if (t < SEQ_LEN && o == FRAME_LEN) begin
                    exp_rx = cap;
                    if (mode == 2) begin
                        check("loop_rx", rx, table_w[w], t);
                    end
                end
            end
            e_done = (t >= SEQ_LEN);
            check("sen", W'(sen), W'(e_sen), t);
            check("sck", W'(sck), W'(e_sck), t);
            check("sdat", W'(sdat), W'(e_sdat), t);
            check("done", W'(done), W'(e_done), t);
            check("rx", rx, exp_rx, t);
            setup = (t == inj_a) || (t == inj_b);
            case (mode)
                0:       sout = 1'b0;
                1:       sout = 1'($urandom_range(0, 1));
                default: sout = sdat;
            endcase
            prev_sout = sout;
        end
        setup = 1'b0;
    endtask

    initial begin
        table_w[0] = 16'hA5C3;
        table_w[1] = 16'h0203;
        table_w[2] = 16'h0405;
        table_w[3] = 16'h8001;
        exp_rx     = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 0);
        check("reset_rx", rx, '0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle", i);
        end

        run_seq(0, -1, -1, -1);
        check("zero_rx_end", rx, '0, SEQ_LEN);
        run_seq(2, -1, -1, -1);
        check("loop_rx_end", rx, table_w[N-1], SEQ_LEN);
        run_seq(1, 80, 67, -1);
        run_seq(1, -1, -1, 40);
        run_seq(1, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comms_master.md
Name: comms_master

Overview:
- SPI master that, on a setup request, streams a fixed configuration table to the HDP display controller. Each table entry is one 16-bit word sent in its own chip-select frame.
- Sits between the top-level control FSM and the HDP serial pins.
- Raises a sticky done flag when the whole table has been sent.
- Captures the slave's serial reply and exposes the last received word.

Parameters:
- CLK_DIV, 2, i_clock cycles per SCK half-period (min 1).
- WORD_BITS, 16, bits per frame, MSB first.
- NUM_WORDS, 4, configuration table length.
- GAP_CYCLES, 4, cycles o_sen is held high between frames (min 1).

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_setup  in  1  start request; level-sampled, a 1-cycle pulse is sufficient.
- i_sout  in  1  serial data from the HDP, sampled on SCK rising.
- o_sen  out  1  chip select, active low.
- o_sck  out  1  SPI clock; idles low; data is captured on the rising edge.
- o_sdat  out  1  serial data to the HDP, changes on SCK falling.
- o_rx_data  out  WORD_BITS  last complete word received on i_sout.
- o_done  out  1  high once the full table has been sent.

Behaviour:
- Reset (asynchronous, i_reset_n=0): o_sen=1, o_sck=0, o_sdat=0, o_done=0, o_rx_data=0; FSM goes to IDLE and the word index is cleared. Reset mid-frame aborts immediately with no partial completion.
- Configuration table (ROM, index 0..3): 16'hA5C3, 16'h0203, 16'h0405, 16'h8001.
- States: IDLE, FRAME, GAP, DONE.
- IDLE:
  - Outputs are at their idle values.
  - i_setup=1 on a clock edge: load word 0 and go to FRAME.
  - On that same edge o_sen goes 0 and o_sdat takes the word's MSB; o_sck stays 0.
- FRAME (SPI mode 0): per word, o_sen is low for exactly (2*WORD_BITS+1)*CLK_DIV cycles.
  - Lead-in: CLK_DIV cycles with o_sck=0, MSB valid on o_sdat.
  - Then WORD_BITS repetitions of: o_sck=1 for CLK_DIV cycles, then o_sck=0 for CLK_DIV cycles.
  - On each SCK rising edge, i_sout is shifted into the rx shift register, MSB first.
  - On each SCK falling edge except the last, o_sdat advances to the next bit.
  - After the final low phase: o_sen=1, o_sdat=0, o_rx_data is updated with the rx shift register, go to GAP.
- GAP:
  - Hold o_sen=1 for GAP_CYCLES cycles.
  - Then, if more words remain, increment the index and re-enter FRAME (o_sen low, new MSB driven on the same edge).
  - Otherwise go to DONE.
- DONE:
  - o_done=1, held sticky.
  - i_setup=1 clears o_done on that edge and restarts the table at word 0 (same as from IDLE).
- i_setup while in FRAME or GAP is ignored; it is not queued.
- Defaults give 66 cycles per frame plus 4 gap cycles, i.e. 70 cycles per word.
- o_done rises 280 cycles after the edge on which i_setup was sampled.
- Exactly NUM_WORDS*WORD_BITS = 64 SCK rising edges per sequence.
- o_sck is never high while o_sen=1.
- o_sdat is stable throughout every SCK high phase.
- All outputs are registered (no combinational paths from inputs).

Test Plan:
- Reset then idle: hold i_reset_n=0 for 3 cycles, release, leave i_setup=0 for 100 cycles -> o_sen=1, o_sck=0, o_sdat=0, o_done=0 throughout.
- Full sequence: 1-cycle i_setup pulse with i_sout=0 ->
  - 4 o_sen low frames of 66 cycles each, 4-cycle gaps between them, 16 SCK rising edges per frame.
  - Bits sampled at SCK rising decode to A5C3, 0203, 0405, 8001.
  - o_done=1 at cycle 280; o_rx_data=0.
- Loopback: tie i_sout=o_sdat, pulse i_setup -> after the last frame o_rx_data=16'h8001; after frame 0 o_rx_data=16'hA5C3.
- Busy-ignore: extra i_setup pulses in frame 1 and in a gap -> sequence timing and content unchanged, o_done still at cycle 280.
- Mid-frame reset: assert i_reset_n=0 at cycle 40 -> outputs idle immediately, o_done stays 0. A new i_setup restarts from word 0 (first frame decodes A5C3).
- Restart from DONE: i_setup pulse while o_done=1 -> o_done=0 next cycle and a full 4-word sequence repeats.
